// File: rtl/mem_sweep_pkg.sv
`default_nettype none
// ============================================================================
// mem_sweep_pkg : shared state encoding and fill-pattern function
// Revision 1.0
// ============================================================================
package mem_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int FILL_CALC_W = 32;

  // Callers zero-extend seed/addr into the calculation width and truncate back.
  function automatic logic [FILL_CALC_W-1:0] fill_value(
    input logic [FILL_CALC_W-1:0] seed,
    input logic [FILL_CALC_W-1:0] addr,
    input logic                   mode
  );
    return mode ? (seed ^ addr) : seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_checker.sv
`default_nettype none
// ============================================================================
// sweep_checker : read-back compare pipeline, mismatch count and pass flag
// Revision 1.0
// ============================================================================
module sweep_checker #(
  parameter int WID_MEM = 4,
  parameter int AW      = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_addr,
  input  logic [WID_MEM-1:0] issue_exp,
  input  logic [WID_MEM-1:0] mem_dout,
  input  logic               finish,
  output logic               pass,
  output logic [AW:0]        err_count,
  output logic [AW-1:0]      first_err_addr
);

  logic               cmp_valid;
  logic [AW-1:0]      cmp_addr;
  logic [WID_MEM-1:0] cmp_exp;
  logic               pass_q;
  logic               mismatch;

  // A flushed (aborted) sweep must not count the read still in flight.
  assign mismatch = cmp_valid && !flush && (mem_dout != cmp_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
      cmp_exp        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass_q         <= 1'b0;
    end else begin
      cmp_valid <= issue_valid && !flush;
      cmp_addr  <= issue_addr;
      cmp_exp   <= issue_exp;
      if (clear) begin
        err_count      <= '0;
        first_err_addr <= '0;
        pass_q         <= 1'b0;
      end else begin
        if (mismatch) begin
          err_count <= err_count + (AW+1)'(1);
          if (err_count == '0) first_err_addr <= cmp_addr;
        end
        if (finish) pass_q <= (err_count == '0);
      end
    end
  end

  assign pass = finish ? (err_count == '0) : pass_q;

endmodule
`default_nettype wire

// File: rtl/mem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// mem_sweep_ctrl : fill-then-verify sweep sequencer with idle user passthrough
// Revision 1.0
// ============================================================================
module mem_sweep_ctrl
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM   = 4,
  parameter int DEPTH_MEM = 8192,
  parameter int AW        = $clog2(DEPTH_MEM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pat_mode,
  input  logic [WID_MEM-1:0] seed,
  input  logic               usr_we,
  input  logic [AW-1:0]      usr_waddr,
  input  logic [WID_MEM-1:0] usr_din,
  input  logic [AW-1:0]      usr_raddr,
  output logic [WID_MEM-1:0] usr_dout,
  output logic               mem_we,
  output logic [AW-1:0]      mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic [AW-1:0]      mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [AW:0]        err_count,
  output logic [AW-1:0]      first_err_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

  state_t             state, state_nx;
  logic [AW-1:0]      cnt, cnt_nx;
  logic               drain, drain_nx;
  logic [WID_MEM-1:0] seed_q;
  logic               mode_q;
  logic               start_ok, abort_ok, issue_valid;
  logic [WID_MEM-1:0] fill_cur;

  assign start_ok = (state == ST_IDLE) && start;
  assign abort_ok = ((state == ST_FILL) || (state == ST_VERIFY)) && abort;
  assign fill_cur = WID_MEM'(fill_value(FILL_CALC_W'(seed_q), FILL_CALC_W'(cnt), mode_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      drain  <= 1'b0;
      seed_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      drain <= drain_nx;
      if (start_ok) begin
        seed_q <= seed;
        mode_q <= pat_mode;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    drain_nx    = drain;
    issue_valid = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = cnt;
    mem_din     = fill_cur;
    mem_raddr   = cnt;
    case (state)
      ST_IDLE: begin
        mem_we    = usr_we;
        mem_waddr = usr_waddr;
        mem_din   = usr_din;
        mem_raddr = usr_raddr;
        if (start) begin
          state_nx = ST_FILL;
          cnt_nx   = '0;
          drain_nx = 1'b0;
        end
      end
      ST_FILL: begin
        mem_we = 1'b1;
        if (abort) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + AW'(1);
          if (cnt == LAST_ADDR) state_nx = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (abort) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          drain_nx = 1'b0;
        end else if (drain) begin
          // Last read is being compared this cycle; nothing left to issue.
          state_nx = ST_DONE;
          drain_nx = 1'b0;
        end else begin
          issue_valid = 1'b1;
          cnt_nx      = cnt + AW'(1);
          if (cnt == LAST_ADDR) drain_nx = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign usr_dout = mem_dout;

  sweep_checker #(
    .WID_MEM (WID_MEM),
    .AW      (AW)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .clear          (start_ok),
    .flush          (abort_ok),
    .issue_valid    (issue_valid),
    .issue_addr     (cnt),
    .issue_exp      (fill_cur),
    .mem_dout       (mem_dout),
    .finish         (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_sweep_ctrl : directed self-checking bench with a 16-word memory model
// Revision 1.0
// ============================================================================
module tb_mem_sweep_ctrl;

  localparam int W = 4;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset, start, abort, pat_mode;
  logic [W-1:0] seed;
  logic         usr_we;
  logic [A-1:0] usr_waddr, usr_raddr;
  logic [W-1:0] usr_din, usr_dout;
  logic         mem_we;
  logic [A-1:0] mem_waddr, mem_raddr;
  logic [W-1:0] mem_din, mem_dout;
  logic         busy, done, pass;
  logic [A:0]   err_count;
  logic [A-1:0] first_err_addr;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [D];
  logic         stuck_en = 1'b0;

  mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .AW(A)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pat_mode(pat_mode),
    .seed(seed), .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_din(usr_din),
    .usr_raddr(usr_raddr), .usr_dout(usr_dout), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_raddr(mem_raddr),
    .mem_dout(mem_dout), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Block RAM model: registered read, optional bit0-stuck-at-1 on words 4 and 9.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_din;
    if (stuck_en && (mem_raddr == 4'd4 || mem_raddr == 4'd9))
      mem_dout <= mem[mem_raddr] | 4'h1;
    else
      mem_dout <= mem[mem_raddr];
  end

  // Launches a sweep and returns the edge index (start edge = 0) at which done
  // is first sampled high, or -1 on timeout. Returns at the negedge inside DONE.
  task automatic run_sweep(input logic mode, input logic [W-1:0] sd,
                           input bit poke_start, output int edges);
    @(negedge clk);
    pat_mode = mode;
    seed     = sd;
    start    = 1'b1;
    edges    = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (poke_start && k == 5);
      if (done === 1'b1) begin
        edges = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pat_mode = 1'b0; seed = '0;
    usr_we = 1'b1; usr_waddr = 4'd3; usr_din = 4'h9; usr_raddr = 4'd2;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (err_count !== 5'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    checks++; if (first_err_addr !== 4'd0) begin errors++; $display("FAIL reset_first_err: got %0d expected 0", first_err_addr); end
    checks++; if ({mem_we, mem_waddr, mem_din, mem_raddr} !== {1'b1, 4'd3, 4'h9, 4'd2}) begin
      errors++; $display("FAIL reset_passthrough: got we=%b wa=%0d din=%h ra=%0d expected we=1 wa=3 din=9 ra=2",
                         mem_we, mem_waddr, mem_din, mem_raddr);
    end
    usr_we = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_const;
    int e;
    run_sweep(1'b0, 4'hA, 1'b1, e);
    checks++; if (e !== 34) begin errors++; $display("FAIL const_latency: got %0d expected 34", e); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL const_pass: got %b expected 1", pass); end
    checks++; if (err_count !== 5'd0) begin errors++; $display("FAIL const_err_count: got %0d expected 0", err_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL const_busy_in_done: got %b expected 1", busy); end
    for (int i = 0; i < D; i++) begin
      checks++; if (mem[i] !== 4'hA) begin errors++; $display("FAIL const_word%0d: got %h expected a", i, mem[i]); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL const_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL const_pass_hold: got %b expected 1", pass); end
  endtask

  task automatic test_fill_xor;
    int e;
    run_sweep(1'b1, 4'h3, 1'b0, e);
    checks++; if (e !== 34) begin errors++; $display("FAIL xor_latency: got %0d expected 34", e); end
    checks++; if (mem[5] !== 4'h6) begin errors++; $display("FAIL xor_word5: got %h expected 6", mem[5]); end
    checks++; if (mem[15] !== 4'hC) begin errors++; $display("FAIL xor_word15: got %h expected c", mem[15]); end
    checks++; if (mem[0] !== 4'h3) begin errors++; $display("FAIL xor_word0: got %h expected 3", mem[0]); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL xor_pass: got %b expected 1", pass); end
  endtask

  task automatic test_stuck_bits;
    int e;
    stuck_en = 1'b1;
    run_sweep(1'b0, 4'h0, 1'b0, e);
    checks++; if (e !== 34) begin errors++; $display("FAIL stuck_latency: got %0d expected 34", e); end
    checks++; if (err_count !== 5'd2) begin errors++; $display("FAIL stuck_err_count: got %0d expected 2", err_count); end
    checks++; if (first_err_addr !== 4'd4) begin errors++; $display("FAIL stuck_first_err: got %0d expected 4", first_err_addr); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b expected 0", pass); end
    repeat (3) @(negedge clk);
    checks++; if (err_count !== 5'd2 || first_err_addr !== 4'd4) begin
      errors++; $display("FAIL stuck_hold: got err=%0d first=%0d expected 2 4", err_count, first_err_addr);
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_abort;
    int e;
    bit saw_done;
    @(negedge clk);
    pat_mode = 1'b0; seed = 4'h7; start = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass: got %b expected 0", pass); end
    checks++; if (err_count !== 5'd0) begin errors++; $display("FAIL abort_err_count: got %0d expected 0", err_count); end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", saw_done); end
    run_sweep(1'b0, 4'h7, 1'b0, e);
    checks++; if (e !== 34) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 34", e); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL abort_restart_pass: got %b expected 1", pass); end
  endtask

  task automatic test_user_port;
    int e;
    int bad;
    usr_we = 1'b1; usr_waddr = 4'd7; usr_din = 4'hF; usr_raddr = 4'd0;
    run_sweep(1'b0, 4'h5, 1'b0, e);
    checks++; if (e !== 34) begin errors++; $display("FAIL user_latency: got %0d expected 34", e); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL user_we_blocked_done: got %b expected 0", mem_we); end
    bad = 0;
    for (int i = 0; i < D; i++) if (mem[i] !== 4'h5) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL user_write_leak: got %0d bad words expected 0 (word7=%h)", bad, mem[7]); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'd7) begin
      errors++; $display("FAIL user_idle_passthrough: got we=%b wa=%0d expected 1 7", mem_we, mem_waddr);
    end
    @(negedge clk);
    usr_we = 1'b0; usr_raddr = 4'd7;
    @(negedge clk);
    checks++; if (usr_dout !== 4'hF) begin errors++; $display("FAIL user_readback: got %h expected f", usr_dout); end
  endtask

  task automatic test_async_reset;
    int e;
    @(negedge clk);
    pat_mode = 1'b0; seed = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (mem_we !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL arst_in_fill: got we=%b busy=%b expected 1 1", mem_we, busy);
    end
    usr_we = 1'b0; usr_waddr = 4'd11;
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++; $display("FAIL arst_outputs: got busy=%b done=%b pass=%b expected 0 0 0", busy, done, pass);
    end
    checks++; if (mem_we !== 1'b0 || mem_waddr !== 4'd11) begin
      errors++; $display("FAIL arst_passthrough: got we=%b wa=%0d expected 0 11", mem_we, mem_waddr);
    end
    @(negedge clk);
    reset = 1'b0;
    run_sweep(1'b1, 4'h9, 1'b0, e);
    checks++; if (e !== 34 || pass !== 1'b1) begin
      errors++; $display("FAIL arst_recovery: got edges=%0d pass=%b expected 34 1", e, pass);
    end
  endtask

  initial begin
    test_reset();
    test_fill_const();
    test_fill_xor();
    test_stuck_bits();
    test_abort();
    test_user_port();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_sweep_ctrl.md
Name: mem_sweep_ctrl

Overview:
Sequencer for one inferred block-RAM memory instance with a write enable, separate read and write addresses, and a 1-cycle registered read.
- On a start pulse it takes over both memory ports, fills every word with a deterministic pattern, then reads every word back and checks it.
- It reports the pass/fail result, the mismatch count and the first failing address.
- When idle, a user port passes straight through to the memory. Used to exercise and confirm memory reinitialisation in hardware.

Parameters:
WID_MEM, 4, memory word width in bits.
DEPTH_MEM, 8192, number of words; must be a power of two.
AW, $clog2(DEPTH_MEM), address width (13 at default).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begins a sweep when sampled high in IDLE.
abort  in  1  cancels a running sweep.
pat_mode  in  1  0: fill value = seed; 1: fill value = seed XOR addr[WID_MEM-1:0]. Sampled at start.
seed  in  WID_MEM  fill seed, sampled at start.
usr_we  in  1  user write enable.
usr_waddr  in  AW  user write address.
usr_din  in  WID_MEM  user write data.
usr_raddr  in  AW  user read address.
usr_dout  out  WID_MEM  user read data; equals mem_dout.
mem_we  out  1  memory write enable.
mem_waddr  out  AW  memory write address.
mem_din  out  WID_MEM  memory write data.
mem_raddr  out  AW  memory read address.
mem_dout  in  WID_MEM  memory read data, valid 1 cycle after mem_raddr.
busy  out  1  high in FILL, VERIFY and DONE.
done  out  1  single-cycle pulse when a sweep completes.
pass  out  1  1 if the last completed sweep had zero mismatches.
err_count  out  AW+1  number of mismatches in the last sweep; cannot overflow.
first_err_addr  out  AW  address of the first mismatch; 0 if none.

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, pass=0, err_count=0, first_err_addr=0. Internal addresses, captured seed and captured pat_mode also clear to 0.
- Reset mid-sweep returns to IDLE immediately. Memory contents are then partially written; no further writes occur.
- States: IDLE, FILL, VERIFY, DONE.
- IDLE:
  - mem_* outputs are combinational passthrough of usr_* signals.
  - start=1 at edge 0: capture seed and pat_mode, clear err_count and first_err_addr, clear pass, go to FILL with address counter = 0.
- FILL:
  - mem_we=1, mem_waddr=cnt, mem_din=fill(cnt).
  - cnt increments each edge. After the edge where cnt = DEPTH_MEM-1 is written (edge DEPTH_MEM), go to VERIFY with cnt=0.
- VERIFY:
  - mem_we=0; mem_raddr=cnt.
  - Issue addresses 0..DEPTH_MEM-1 in consecutive cycles.
  - One-stage pipeline: valid flag and expected value are registered alongside each issued address.
  - On the following cycle, mem_dout is compared against the registered expected value. A mismatch increments err_count; the first mismatch also loads first_err_addr.
  - After the last compare registers (edge 2*DEPTH_MEM+1), go to DONE.
- DONE: done=1 and pass=(err_count==0) for exactly one cycle, then IDLE.
  - done asserts on the cycle after edge 2*DEPTH_MEM+1, i.e. 2*DEPTH_MEM+2 edges after start is sampled.
- Busy-state port rules:
  - In FILL, VERIFY and DONE, usr_we is ignored (dropped, never queued) and usr_raddr is not forwarded.
  - usr_dout still mirrors mem_dout.
- start while busy: ignored.
- abort=1 in FILL or VERIFY: IDLE at the next edge. No done pulse, pass=0, err_count holds its partial value.
- abort in IDLE or DONE: ignored.
- If abort and start are both high in IDLE, start wins.
- pass, err_count and first_err_addr hold their values after DONE until the next accepted start.
- Counter wrap: cnt is AW bits and wraps to 0 at the FILL→VERIFY transition. No extra idle cycle is inserted between FILL and VERIFY.
- fill(a): seed if pat_mode=0; seed ^ a[WID_MEM-1:0] if pat_mode=1. If WID_MEM > AW, zero-extend a.

Decomposition:
- Package mem_sweep_pkg: state enum type (IDLE, FILL, VERIFY, DONE) and a fill_value(seed, addr, mode) function.
- Sub-module sweep_checker: owns the compare pipeline register, err_count, first_err_addr and the pass computation.
- The top FSM drives sweep_checker with issue-valid, address and expected value.

Test Plan:
- DEPTH_MEM=16, WID_MEM=4, pat_mode=0, seed=4'hA, ideal memory model → done exactly 34 edges after start, pass=1, err_count=0, all 16 words = 4'hA.
- pat_mode=1, seed=4'h3 → word 5 = 4'h6, word 15 = 4'hC; pass=1.
- Memory model with bit0 stuck at 1 on addresses 4 and 9, pat_mode=0, seed=4'h0 → err_count=2, first_err_addr=4, pass=0.
- abort at the 3rd VERIFY cycle → IDLE next edge, no done, busy=0, pass=0; a new start then completes normally.
- usr_we=1 held throughout a sweep with usr_din=4'hF → no user write reaches the memory (all words = fill pattern). In IDLE, a user write to address 7 and a read of address 7 → usr_dout=4'hF one cycle after the read.
- reset asserted mid-FILL, asynchronously → outputs at reset values immediately, mem_we=usr_we passthrough. start pulsed during busy → ignored, sweep length unchanged.
